clk_wiz: RTL and testbench

//  Synthesizable clock-generator with AXI4-Lite dynamic reconfiguration, replacing the vendor clocking wizard

---
 rtl/vga_pkg.sv | 28 ++
 rtl/clk_wiz_div.sv | 71 +++++++
 rtl/clk_wiz.sv | 180 ++++++++++++++++++
 tb/tb_clk_wiz.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the clock wizard: register map, response codes, CFG0 layout,
// apply/lock FSM states and the target-frequency helper.
package vga_pkg;

  localparam logic [10:0] AddrStatus = 11'h004;
  localparam logic [10:0] AddrCfg0   = 11'h208;
  localparam logic [10:0] AddrCfg23  = 11'h25C;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  localparam int unsigned DivW = 50;  // target_khz (18b) shifted left by 32
  localparam int unsigned DsrW = 17;  // holds the reference frequency in kHz

  typedef struct packed {
    logic [9:0] frac;     // 1/1000 MHz
    logic [7:0] int_mhz;
  } cfg0_t;

  typedef enum logic [1:0] {StIdle, StDivide, StWaitLock, StLocked} apply_st_e;

  function automatic logic [17:0] target_khz(input cfg0_t c);
    logic [9:0] f;
    f = (c.frac > 10'd999) ? 10'd999 : c.frac;
    return (18'(c.int_mhz) * 18'd1000) + 18'(f);
  endfunction

endpackage

// File: rtl/clk_wiz_div.sv
// Restoring divider producing one quotient bit per cycle; done pulses for one cycle at the end.
// A start while busy discards the running division and begins a new one.
module clk_wiz_div
  import vga_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [DivW-1:0] dividend_i,
  input  logic [DsrW-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [DivW-1:0] quot_o
);

  localparam int unsigned CntW = $clog2(DivW + 1);

  // Dividend shifts out of the top while quotient bits shift in at the bottom.
  logic [DivW-1:0] dq_q, dq_d;
  logic [DsrW-1:0] rem_q, rem_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DsrW:0]   rem_sh;
  logic            ge;

  always_comb begin
    rem_sh = {rem_q, dq_q[DivW-1]};
    ge     = (rem_sh >= {1'b0, divisor_i});
    dq_d   = dq_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      dq_d   = dividend_i;
      rem_d  = '0;
      cnt_d  = CntW'(DivW);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = ge ? DsrW'(rem_sh - {1'b0, divisor_i}) : rem_sh[DsrW-1:0];
      dq_d  = {dq_q[DivW-2:0], ge};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dq_q   <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      dq_q   <= dq_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = dq_q;

endmodule

// File: rtl/clk_wiz.sv
// NCO clock generator with AXI4-Lite configuration: CFG0 holds the pixel frequency, CFG23 applies
// it, and locked drops until the new phase increment is computed and LOCK_CYCLES have elapsed.
module clk_wiz
  import vga_pkg::*;
#(
  parameter int unsigned CLK_IN_KHZ  = 100000,
  parameter int unsigned DEFAULT_INT = 25,
  parameter int unsigned LOCK_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [10:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [10:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        clk_out1,
  output logic        locked
);

  localparam logic [DsrW-1:0] Divisor  = DsrW'(CLK_IN_KHZ);
  localparam logic [DivW-1:0] QuotMax  = DivW'(32'h8000_0000);
  localparam int unsigned     CntW     = $clog2(LOCK_CYCLES) + 1;
  localparam logic [CntW-1:0] LockLast = CntW'(LOCK_CYCLES - 1);
  localparam cfg0_t           CfgReset = '{frac: 10'd0, int_mhz: 8'(DEFAULT_INT)};

  logic        aw_rdy_q, aw_rdy_d, aw_hold_q, aw_hold_d, w_rdy_q, w_rdy_d, w_hold_q, w_hold_d;
  logic [8:0]  awaddr_q, awaddr_d;
  logic [17:0] wdata_q, wdata_d;
  logic [2:0]  wstrb_q, wstrb_d;
  logic        bvalid_q, bvalid_d, ar_rdy_q, ar_rdy_d, rvalid_q, rvalid_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  cfg0_t       cfg_q, cfg_d;
  logic        apply_pend_q;
  apply_st_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0] inc_q, inc_d, acc_q, acc_d;
  logic        aw_hs, w_hs, ar_hs, do_write, apply_req;
  logic        wr_status, wr_cfg0, wr_cfg23;
  logic        div_busy, div_done;
  logic [DivW-1:0] div_quot;
  logic        unused_in;

  assign unused_in = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata[31:18], s_axi_wstrb[3]};

  assign wr_status = (awaddr_q == AddrStatus[10:2]);
  assign wr_cfg0   = (awaddr_q == AddrCfg0[10:2]);
  assign wr_cfg23  = (awaddr_q == AddrCfg23[10:2]);

  always_comb begin
    aw_hs     = s_axi_awvalid & aw_rdy_q;
    w_hs      = s_axi_wvalid & w_rdy_q;
    do_write  = aw_hold_q & w_hold_q & ~bvalid_q;
    aw_hold_d = (aw_hold_q | aw_hs) & ~do_write;
    w_hold_d  = (w_hold_q | w_hs) & ~do_write;
    awaddr_d  = aw_hs ? s_axi_awaddr[10:2] : awaddr_q;
    wdata_d   = w_hs ? s_axi_wdata[17:0] : wdata_q;
    wstrb_d   = w_hs ? s_axi_wstrb[2:0] : wstrb_q;
    bvalid_d  = do_write | (bvalid_q & ~s_axi_bready);
    bresp_d   = bresp_q;
    if (do_write) bresp_d = (wr_status | wr_cfg0 | wr_cfg23) ? RespOkay : RespSlverr;
    aw_rdy_d  = ~aw_hold_d & ~bvalid_d;
    w_rdy_d   = ~w_hold_d & ~bvalid_d;
    cfg_d     = cfg_q;
    if (do_write && wr_cfg0) begin
      if (wstrb_q[0]) cfg_d[7:0]   = wdata_q[7:0];
      if (wstrb_q[1]) cfg_d[15:8]  = wdata_q[15:8];
      if (wstrb_q[2]) cfg_d[17:16] = wdata_q[17:16];
    end
    // The flag set by reset provides the implicit apply right after reset is released.
    apply_req = apply_pend_q | (do_write & wr_cfg23 & (wdata_q[1:0] == 2'b11));
  end

  always_comb begin
    ar_hs    = s_axi_arvalid & ar_rdy_q;
    rvalid_d = ar_hs | (rvalid_q & ~s_axi_rready);
    ar_rdy_d = ~rvalid_d;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rdata_d = '0;
      rresp_d = RespOkay;
      if (s_axi_araddr[10:2] == AddrStatus[10:2])     rdata_d = {31'b0, locked};
      else if (s_axi_araddr[10:2] == AddrCfg0[10:2])  rdata_d = {14'b0, cfg_q};
      else if (s_axi_araddr[10:2] != AddrCfg23[10:2]) rresp_d = RespSlverr;
    end
  end

  // Apply/lock FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    if (apply_req) begin
      state_d = StDivide;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StDivide:   if (!div_busy) state_d = StWaitLock;
        StWaitLock: if (cnt_q >= LockLast) state_d = StLocked;
        default:    state_d = state_q;
      endcase
    end
  end

  // Apply/lock FSM: outputs
  always_comb begin
    locked = (state_q == StLocked);
  end

  // NCO keeps running on the old increment until the divider delivers the new one.
  always_comb begin
    acc_d = acc_q + inc_q;
    inc_d = inc_q;
    if (div_done && !apply_req && state_q == StDivide) begin
      inc_d = (div_quot > QuotMax) ? QuotMax[31:0] : div_quot[31:0];
      acc_d = '0;
    end
  end

  clk_wiz_div u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (apply_req),
    .dividend_i ({target_khz(cfg_q), 32'b0}),
    .divisor_i  (Divisor),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quot_o     (div_quot)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_rdy_q <= 1'b0;  aw_hold_q <= 1'b0;  awaddr_q <= '0;
      w_rdy_q  <= 1'b0;  w_hold_q  <= 1'b0;  wdata_q  <= '0;  wstrb_q <= '0;
      bvalid_q <= 1'b0;  bresp_q   <= '0;
      ar_rdy_q <= 1'b0;  rvalid_q  <= 1'b0;  rdata_q  <= '0;  rresp_q <= '0;
      cfg_q    <= CfgReset;
      apply_pend_q <= 1'b1;
      state_q  <= StIdle;
      cnt_q    <= '0;
      inc_q    <= '0;
      acc_q    <= '0;
    end else begin
      aw_rdy_q <= aw_rdy_d;  aw_hold_q <= aw_hold_d;  awaddr_q <= awaddr_d;
      w_rdy_q  <= w_rdy_d;   w_hold_q  <= w_hold_d;   wdata_q  <= wdata_d;  wstrb_q <= wstrb_d;
      bvalid_q <= bvalid_d;  bresp_q   <= bresp_d;
      ar_rdy_q <= ar_rdy_d;  rvalid_q  <= rvalid_d;   rdata_q  <= rdata_d;  rresp_q <= rresp_d;
      cfg_q    <= cfg_d;
      apply_pend_q <= 1'b0;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      inc_q    <= inc_d;
      acc_q    <= acc_d;
    end
  end

  assign s_axi_awready = aw_rdy_q;
  assign s_axi_wready  = w_rdy_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = ar_rdy_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign clk_out1      = acc_q[31];

endmodule

// File: tb/tb_clk_wiz.sv
// Directed bench for clk_wiz: a frequency/lock model computed from the register rules, a per-cycle
// lock-window checker, and literal expectations for register reads and responses.
module tb_clk_wiz;

  localparam int unsigned ClkInKhz   = 100000;
  localparam int unsigned LockCycles = 64;
  localparam logic [10:0] AStatus = 11'h004, ACfg0 = 11'h208, ACfg23 = 11'h25C, ABad = 11'h100;
  localparam logic [1:0]  Okay = 2'b00, Slverr = 2'b10;
  localparam int          RstMark = -1000;

  logic clk = 1'b0, rst = 1'b1;
  logic [10:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid, clk_out1, locked;
  logic [1:0] bresp, rresp;

  always #5 clk = ~clk;

  clk_wiz #(.CLK_IN_KHZ(ClkInKhz), .DEFAULT_INT(25), .LOCK_CYCLES(LockCycles)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .clk_out1(clk_out1), .locked(locked)
  );

  int n_cmp = 0, n_bad = 0;
  int since = RstMark;
  bit apply_armed = 0;
  logic bv_prev = 0;
  int b_rises = 0;
  logic [31:0] cfg_model = 32'h19;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_range(input string nm, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Phase increment from the frequency rules: (kHz << 32) / f_in, capped at half the input rate.
  function automatic logic [31:0] model_inc(input logic [31:0] cfg);
    longint unsigned i_mhz, f, q;
    i_mhz = 64'(cfg[7:0]);
    f     = 64'(cfg[17:8]);
    if (f > 999) f = 999;
    q = ((i_mhz * 1000 + f) << 32) / ClkInKhz;
    if (q > 64'h8000_0000) q = 64'h8000_0000;
    return q[31:0];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r & 32'h0003_FFFF;
  endfunction

  // Lock window: low for LockCycles after an apply (or reset release), high from LockCycles+2 on.
  always @(negedge clk) begin
    if (rst) begin
      check("locked_in_reset", {31'b0, locked}, 32'h0);
      since = RstMark;
      apply_armed = 0;
    end else begin
      if (since == RstMark) since = -1;
      else if (apply_armed && bvalid && !bv_prev) begin
        since = 0;
        apply_armed = 0;
      end else if (since < 1000000) since++;
      if (since >= 0 && since < int'(LockCycles))
        check("locked_low_window", {31'b0, locked}, 32'h0);
      else if (since >= int'(LockCycles) + 2)
        check("locked_high", {31'b0, locked}, 32'h1);
    end
    if (bvalid && !bv_prev) b_rises++;
    bv_prev = bvalid;
  end

  task automatic axi_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] exp, input bit is_apply, input string nm);
    bit aw_go, w_go;
    @(posedge clk); #1;
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
    if (is_apply) apply_armed = 1;
    for (int n = 0; n < 20 && (awvalid || wvalid); n++) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_go) awvalid = 0;
      if (w_go) wvalid = 0;
    end
    check({nm, "_accepted"}, {31'b0, awvalid | wvalid}, 32'h0);
    awvalid = 0; wvalid = 0;
    for (int n = 0; n < 20 && !bvalid; n++) begin
      @(posedge clk); #1;
    end
    check({nm, "_bvalid"}, {31'b0, bvalid}, 32'h1);
    check({nm, "_bresp"}, {30'b0, bresp}, {30'b0, exp});
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    if (a == ACfg0) cfg_model = merge(cfg_model, d, s);
  endtask

  task automatic axi_read(input logic [10:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                          input string nm);
    bit go;
    @(posedge clk); #1;
    araddr = a; arvalid = 1;
    for (int n = 0; n < 20 && arvalid; n++) begin
      go = arready;
      @(posedge clk); #1;
      if (go) arvalid = 0;
    end
    check({nm, "_accepted"}, {31'b0, arvalid}, 32'h0);
    arvalid = 0;
    for (int n = 0; n < 20 && !rvalid; n++) begin
      @(posedge clk); #1;
    end
    check({nm, "_rvalid"}, {31'b0, rvalid}, 32'h1);
    check({nm, "_rdata"}, rdata, exp_d);
    check({nm, "_rresp"}, {30'b0, rresp}, {30'b0, exp_r});
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic wait_lock();
    repeat (LockCycles + 4) @(negedge clk);
  endtask

  // Rising edges of clk_out1 over n cycles must equal floor/ceil of n*inc/2^32.
  task automatic nco_check(input string nm, input logic [31:0] cfg, input int n);
    longint unsigned prod;
    int lo, hi, r;
    logic prev;
    prod = 64'(model_inc(cfg)) * 64'(n);
    lo = int'(prod >> 32);
    hi = lo + ((prod[31:0] != 0) ? 1 : 0);
    r = 0;
    @(negedge clk);
    prev = clk_out1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (clk_out1 && !prev) r++;
      prev = clk_out1;
    end
    check_range(nm, r, lo, hi);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] applied;
    int b0;
    bit go;
    repeat (4) @(negedge clk);
    check("rst_awready", {31'b0, awready}, 0);
    check("rst_wready", {31'b0, wready}, 0);
    check("rst_arready", {31'b0, arready}, 0);
    check("rst_bvalid", {31'b0, bvalid}, 0);
    check("rst_rvalid", {31'b0, rvalid}, 0);
    check("rst_resp", {28'b0, bresp, rresp}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_clk_out1", {31'b0, clk_out1}, 0);
    check("model_25mhz", model_inc(32'h19), 32'h4000_0000);
    check("model_108mhz", model_inc(32'h6C), 32'h8000_0000);
    check("model_12125khz", model_inc(32'h7D0C), 32'd520764784);
    check("model_zero", model_inc(32'h0), 32'h0);
    @(posedge clk); #1 rst = 0;
    wait_lock();
    axi_read(AStatus, 32'h1, Okay, "status_after_reset");
    axi_read(ACfg0, 32'h19, Okay, "cfg0_default");
    applied = 32'h19;
    nco_check("nco_25mhz", applied, 1000);

    axi_write(ACfg0, 32'h6C, 4'hF, Okay, 0, "wr_cfg0_108");
    axi_write(ACfg23, 32'h3, 4'hF, Okay, 1, "apply_108");
    applied = cfg_model;
    wait_lock();
    nco_check("nco_108mhz", applied, 1000);

    axi_write(ACfg0, 32'h7D0C, 4'hF, Okay, 0, "wr_cfg0_12125");
    nco_check("nco_unchanged_before_apply", applied, 400);
    axi_read(ACfg0, 32'h7D0C, Okay, "cfg0_readback");
    axi_write(ACfg23, 32'h3, 4'hF, Okay, 1, "apply_12125");
    applied = cfg_model;
    axi_read(AStatus, 32'h0, Okay, "status_relocking");
    wait_lock();
    axi_read(AStatus, 32'h1, Okay, "status_relocked");
    nco_check("nco_12125khz", applied, 1000);

    axi_write(ACfg0, 32'hFFFF_FF19, 4'h1, Okay, 0, "wr_cfg0_strb");
    axi_read(ACfg0, 32'h7D19, Okay, "cfg0_strb_readback");
    axi_write(ACfg23, 32'h3, 4'hF, Okay, 1, "apply_25125");
    applied = cfg_model;
    wait_lock();
    nco_check("nco_25125khz", applied, 1000);

    // aw leads w by 3 cycles; bready held low for 5 cycles.
    b0 = b_rises;
    @(posedge clk); #1;
    awaddr = ACfg0; awvalid = 1;
    for (int n = 0; n < 20 && awvalid; n++) begin
      go = awready;
      @(posedge clk); #1;
      if (go) awvalid = 0;
    end
    check("split_aw_accepted", {31'b0, awvalid}, 0);
    awvalid = 0;
    repeat (2) @(posedge clk); #1;
    check("split_no_early_b", {31'b0, bvalid}, 0);
    wdata = 32'h19; wstrb = 4'hF; wvalid = 1;
    for (int n = 0; n < 20 && wvalid; n++) begin
      go = wready;
      @(posedge clk); #1;
      if (go) wvalid = 0;
    end
    check("split_w_accepted", {31'b0, wvalid}, 0);
    wvalid = 0;
    for (int n = 0; n < 20 && !bvalid; n++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("split_bvalid_held", {31'b0, bvalid}, 1);
      check("split_awready_low", {31'b0, awready}, 0);
    end
    check("split_bresp", {30'b0, bresp}, {30'b0, Okay});
    @(posedge clk); #1 bready = 1;
    @(posedge clk); #1 bready = 0;
    repeat (5) @(negedge clk);
    check("split_one_response", 32'(b_rises - b0), 32'h1);
    cfg_model = 32'h19;
    axi_read(ACfg0, 32'h19, Okay, "split_readback");

    axi_write(ABad, 32'h55, 4'hF, Slverr, 0, "wr_unmapped");
    axi_read(ABad, 32'h0, Slverr, "rd_unmapped");
    axi_read(ACfg23, 32'h0, Okay, "rd_cfg23");
    axi_read(ACfg0, 32'h19, Okay, "cfg0_after_bad_write");

    axi_write(ACfg0, 32'h0, 4'hF, Okay, 0, "wr_cfg0_zero");
    axi_write(ACfg23, 32'h3, 4'hF, Okay, 1, "apply_zero");
    applied = cfg_model;
    wait_lock();
    nco_check("nco_zero", applied, 200);
    check("zero_clk_low", {31'b0, clk_out1}, 0);

    axi_write(ACfg0, 32'h6C, 4'hF, Okay, 0, "wr_cfg0_pre_rst");
    axi_write(ACfg23, 32'h3, 4'hF, Okay, 1, "apply_pre_rst");
    repeat (55) @(negedge clk);
    @(posedge clk); #1 rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    cfg_model = 32'h19;
    applied = 32'h19;
    wait_lock();
    axi_read(ACfg0, 32'h19, Okay, "cfg0_after_rst");
    nco_check("nco_after_rst", applied, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
